wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback-port arbiter for the integer register file. It shares the single register-file write port between two producers: the ALU writeback path and the load (memory) writeback path. Loads have priority, with a bounded-starvation guarantee for the ALU. The granted write is registered and driven onto the register file's `wr_en`/`rd`/`rd_value` inputs one cycle after acceptance.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of write data.
- `ADDR_WIDTH`, 5, width of destination register index.
- `STARVE_LIMIT`, 4, maximum consecutive cycles the ALU may lose arbitration while requesting. Legal range is 1..15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_stall`  in  1  pipeline freeze; blocks all grants while high.
- `alu_valid`  in  1  ALU writeback request.
- `alu_rd`  in  ADDR_WIDTH  ALU destination register.
- `alu_value`  in  DATA_WIDTH  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load writeback request.
- `mem_rd`  in  ADDR_WIDTH  load destination register.
- `mem_value`  in  DATA_WIDTH  load data.
- `mem_ready`  out  1  load request accepted this cycle.
- `wr_en`  out  1  register-file write enable (registered).
- `rd`  out  ADDR_WIDTH  register-file write index (registered).
- `rd_value`  out  DATA_WIDTH  register-file write data (registered).
- `starved`  out  1  high while the FSM is in FORCE_ALU.

## Operation
Handshake:
- A transfer occurs when `x_valid && x_ready`.
- A requester holds `valid`, `rd` and `value` stable until the transfer.
- At most one of `alu_ready`/`mem_ready` is high in any cycle.
- Both ready outputs are 0 whenever `wb_stall` is high.

FSM, two states:
- NORMAL (reset state):
  - `mem_ready = mem_valid`.
  - `alu_ready = alu_valid && !mem_valid`.
- FORCE_ALU:
  - `alu_ready = alu_valid`.
  - `mem_ready = mem_valid && !alu_valid`.

Starvation counter `starve_cnt`, width clog2(STARVE_LIMIT+1), reset 0:
- In NORMAL, when not stalled and both valids are high (the load wins), the counter increments.
- In NORMAL, when not stalled and an ALU transfer occurs, the counter clears.
- In NORMAL, when not stalled and `alu_valid` is low, the counter clears.
- During `wb_stall`, the counter and FSM state hold.
- NORMAL -> FORCE_ALU on the cycle the increment makes `starve_cnt == STARVE_LIMIT`.
- FORCE_ALU -> NORMAL when an ALU transfer occurs, or when `alu_valid` is low (not stalled). The counter clears on that exit.

Write stage:
- On any transfer: `wr_en <= (granted rd != 0)`, `rd <= granted rd`, `rd_value <= granted value`.
- A transfer to x0 is consumed (ready high) but produces no write; `rd`/`rd_value` still update.
- With no transfer: `wr_en <= 0`, and `rd`/`rd_value` hold their values.

## Timing
- Reset values (asynchronous on `rst_n` low): `wr_en`=0, `rd`=0, `rd_value`=0, state NORMAL, `starve_cnt`=0, `starved`=0.
- The ready outputs are combinational in `valid`, `wb_stall` and state. They are 0 while in reset.
- Latency is one cycle: a transfer in cycle N gives `wr_en`/`rd`/`rd_value` valid in cycle N+1. The register file commits at the end of N+1.
- Throughput is one write per cycle, sustained.
- `starved` is registered and reflects the current state.
- Reset asserted mid-stream drops any accepted-but-unwritten transfer. `wr_en` goes to 0 immediately.
- Simultaneous valids in NORMAL: load wins. In FORCE_ALU: ALU wins.

## Test plan
- Reset: assert `rst_n`=0 mid-transfer -> `wr_en`=0, `rd`=0, `rd_value`=0 immediately. The first post-reset grant goes to the load path.
- Single ALU: `alu_valid`=1, `alu_rd`=5, `alu_value`=0xDEADBEEF, `mem_valid`=0 -> `alu_ready`=1 same cycle. Next cycle `wr_en`=1, `rd`=5, `rd_value`=0xDEADBEEF.
- Conflict: both valid for 10 cycles with STARVE_LIMIT=4 -> mem granted for cycles 0-3. `starved`=1 at cycle 4 and the ALU is granted at cycle 4. Mem is granted again at cycle 5, and the pattern repeats.
- x0 write: `mem_valid`=1, `mem_rd`=0, `mem_value`=0x1234 -> `mem_ready`=1, next-cycle `wr_en`=0.
- Stall: both valid, `wb_stall`=1 for 3 cycles -> both ready=0, `wr_en`=0, `starve_cnt` unchanged. Arbitration resumes from the held state when the stall drops.
- Back-to-back: mem transfers on 4 consecutive cycles with distinct rd -> 4 consecutive `wr_en`=1 cycles with matching rd/value, in order.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: shares the register-file write port between the ALU and load paths.
// Loads win by default; a starvation counter forces one ALU grant after STARVE_LIMIT consecutive losses.
module wb_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_stall,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_value,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_value,
  output logic                  mem_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] rd_value,
  output logic                  starved
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_ALU = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   rd_value_q, rd_value_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      rd_q         <= '0;
      rd_value_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      rd_q         <= rd_d;
      rd_value_q   <= rd_value_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (!wb_stall) begin
      unique case (state_q)
        NORMAL: begin
          if (alu_valid && mem_valid) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
            if (starve_cnt_d == CNT_W'(STARVE_LIMIT)) state_d = FORCE_ALU;
          end else begin
            starve_cnt_d = '0;
          end
        end
        // Unstalled FORCE_ALU either grants the ALU or sees it idle; both exit.
        FORCE_ALU: begin
          state_d      = NORMAL;
          starve_cnt_d = '0;
        end
        default: begin
          state_d      = NORMAL;
          starve_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (rst_n && !wb_stall) begin
      unique case (state_q)
        NORMAL: begin
          mem_ready = mem_valid;
          alu_ready = alu_valid && !mem_valid;
        end
        FORCE_ALU: begin
          alu_ready = alu_valid;
          mem_ready = mem_valid && !alu_valid;
        end
        default: begin
          alu_ready = 1'b0;
          mem_ready = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_en_d    = 1'b0;
    rd_d       = rd_q;
    rd_value_d = rd_value_q;
    if (alu_ready) begin
      wr_en_d    = (alu_rd != '0);
      rd_d       = alu_rd;
      rd_value_d = alu_value;
    end else if (mem_ready) begin
      wr_en_d    = (mem_rd != '0);
      rd_d       = mem_rd;
      rd_value_d = mem_value;
    end
  end

  assign wr_en    = wr_en_q;
  assign rd       = rd_q;
  assign rd_value = rd_value_q;
  assign starved  = (state_q == FORCE_ALU);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued at grant time and
// checked against the registered write port one cycle later.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_value;
  logic        mem_ready;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic        starved;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  wr_t         sb[$];
  logic [4:0]  held_rd;
  logic [31:0] held_val;
  int          vectors = 0;
  int          miscompares = 0;

  wb_arbiter #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (5),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_stall (wb_stall),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_value(alu_value),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_rd   (mem_rd),
    .mem_value(mem_value),
    .mem_ready(mem_ready),
    .wr_en    (wr_en),
    .rd       (rd),
    .rd_value (rd_value),
    .starved  (starved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: drive, check readys/starved, queue the expected write,
  // then check the registered write port after the clock edge.
  task automatic step(input logic stall, input logic av, input logic [4:0] ard,
                      input logic [31:0] aval, input logic mv, input logic [4:0] mrd,
                      input logic [31:0] mval, input logic exp_ar, input logic exp_mr,
                      input logic exp_st);
    wr_t e;
    wr_t got;
    @(negedge clk);
    wb_stall  = stall;
    alu_valid = av;
    alu_rd    = ard;
    alu_value = aval;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_value = mval;
    #1;
    check("alu_ready", 32'(alu_ready), 32'(exp_ar));
    check("mem_ready", 32'(mem_ready), 32'(exp_mr));
    check("starved", 32'(starved), 32'(exp_st));
    if (exp_ar) begin
      e.wr = (ard != 5'd0); e.rd = ard; e.val = aval;
    end else if (exp_mr) begin
      e.wr = (mrd != 5'd0); e.rd = mrd; e.val = mval;
    end else begin
      e.wr = 1'b0; e.rd = held_rd; e.val = held_val;
    end
    held_rd  = e.rd;
    held_val = e.val;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check("wr_en", 32'(wr_en), 32'(got.wr));
      check("rd", 32'(rd), 32'(got.rd));
      check("rd_value", rd_value, got.val);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    wb_stall  = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_value = '0;
    mem_valid = 1'b1;
    mem_rd    = 5'd3;
    mem_value = 32'h0000_0033;
    held_rd   = '0;
    held_val  = '0;
    #12;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_rd_value", rd_value, 32'd0);
    check("rst_starved", 32'(starved), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_valid = 1'b0;

    // Single ALU write, x0 load, idle
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 1, 0, 0);
    step(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h0000_1234, 0, 1, 0);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);

    // Ten cycles of conflict: mem x4, forced ALU, mem x4, forced ALU
    for (int i = 0; i < 10; i++) begin
      logic f;
      f = (i == 4) || (i == 9);
      step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, f, !f, f);
    end

    // Stall holds the starvation count mid-run
    step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 0, 1, 0);
    step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 0, 0, 0);
    step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 0, 1, 0);
    step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 0, 1, 0);
    step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 1, 0, 1);

    // Back-to-back loads with distinct destinations
    for (int i = 0; i < 4; i++)
      step(0, 0, 5'd0, 32'h0, 1, 5'(10 + i), 32'h1000_0000 + 32'(i), 0, 1, 0);

    // Reach FORCE_ALU, then reset asynchronously while requests are pending
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 0, 1, 0);
    check("pre_rst_starved", 32'(starved), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_rd", 32'(rd), 32'd0);
    check("mid_rst_rd_value", rd_value, 32'd0);
    check("mid_rst_starved", 32'(starved), 32'd0);
    check("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
    check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    held_rd  = '0;
    held_val = '0;
    sb.delete();
    step(0, 1, 5'd7, 32'hA5A5_0007, 1, 5'd9, 32'h5A5A_0009, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
